// File: rtl/layer_compositor_pkg.sv
// Shared types and helpers for the layer compositor.
//   rgb_t       : packed {r,g,b} pixel at the reference channel width
//   WHITE/BLACK : all-ones / all-zeros pixel constants
//   prio_t      : result of the priority pick (valid + winning index)
//   prio_select : lowest set index of an on-vector (index 0 wins)
package layer_compositor_pkg;

    localparam int unsigned COLOR_W_PKG = 4;
    localparam int unsigned MAX_LAYERS  = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned CNT_W       = 8;

    typedef struct packed {
        logic [COLOR_W_PKG-1:0] r;
        logic [COLOR_W_PKG-1:0] g;
        logic [COLOR_W_PKG-1:0] b;
    } rgb_t;

    localparam rgb_t WHITE = '1;
    localparam rgb_t BLACK = '0;

    typedef enum logic {
        BLINK_HIDDEN  = 1'b0,
        BLINK_VISIBLE = 1'b1
    } blink_phase_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Lowest set bit wins; scanning from the top lets lower indices overwrite.
    function automatic prio_t prio_select(input logic [MAX_LAYERS-1:0] on_vec);
        prio_t p;
        p = '0;
        for (int i = int'(MAX_LAYERS) - 1; i >= 0; i--) begin
            if (on_vec[i]) begin
                p.valid = 1'b1;
                p.idx   = IDX_W'(i);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/layer_compositor_if.sv
// Pixel bus between the ROM readers / DAC pins and the compositor.
//   blank, bg_rgb, layer_on, layer_rgb : pixel inputs (driven by master)
//   Red, Green, Blue, blank_out        : composited pixel (driven by slave)
interface layer_compositor_if #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned COLOR_W    = 4
) ();

    logic                              blank;
    logic [3*COLOR_W-1:0]              bg_rgb;
    logic [NUM_LAYERS-1:0]             layer_on;
    logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb;
    logic [COLOR_W-1:0]                Red;
    logic [COLOR_W-1:0]                Green;
    logic [COLOR_W-1:0]                Blue;
    logic                              blank_out;

    modport master (
        output blank, bg_rgb, layer_on, layer_rgb,
        input  Red, Green, Blue, blank_out
    );

    modport slave (
        input  blank, bg_rgb, layer_on, layer_rgb,
        output Red, Green, Blue, blank_out
    );

endinterface

// File: rtl/layer_compositor_fx_ctrl.sv
// Per-layer hit-flash controller.
//   vga_clk, Reset : clock, synchronous active-high reset
//   frame_tick     : frame start pulse (decrements a running count)
//   flash_trig     : hit pulse (reloads the count, wins over frame_tick)
//   flash_active   : count is nonzero
//   flash_phase    : LSB of the count; 1 selects white
module layer_fx_ctrl
    import layer_compositor_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 8
) (
    input  logic vga_clk,
    input  logic Reset,
    input  logic frame_tick,
    input  logic flash_trig,
    output logic flash_active,
    output logic flash_phase
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Reload beats decrement; decrement saturates at zero.
    always_comb begin
        cnt_nxt = cnt;
        if (flash_trig) begin
            cnt_nxt = CNT_W'(FLASH_FRAMES);
        end else if (frame_tick && (cnt != '0)) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Status flags are registered from the next count so they track cnt exactly.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            cnt          <= '0;
            flash_active <= 1'b0;
            flash_phase  <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            flash_active <= (cnt_nxt != '0);
            flash_phase  <= cnt_nxt[0];
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite layer compositor with enable, blink and hit-flash effects.
//   vga_clk, Reset : pixel clock, synchronous active-high reset
//   frame_tick     : frame start pulse (advances blink and flash counters)
//   layer_en       : static per-layer enable
//   blink_en       : per-layer blink mode
//   flash_trig     : per-layer hit pulse
//   flash_active   : per-layer flash in progress
//   pix            : pixel bus (inputs in, registered RGB + blank_out out)
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int unsigned NUM_LAYERS   = 4,
    parameter int unsigned COLOR_W      = 4,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned BLINK_HALF   = 16
) (
    input  logic                  vga_clk,
    input  logic                  Reset,
    input  logic                  frame_tick,
    input  logic [NUM_LAYERS-1:0] layer_en,
    input  logic [NUM_LAYERS-1:0] blink_en,
    input  logic [NUM_LAYERS-1:0] flash_trig,
    output logic [NUM_LAYERS-1:0] flash_active,
    layer_compositor_if.slave     pix
);

    localparam int unsigned PIX_W = 3 * COLOR_W;

    // Global blink timer shared by all layers.
    logic [CNT_W-1:0] blink_cnt;
    blink_phase_e     blink_vis;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            blink_cnt <= '0;
            blink_vis <= BLINK_VISIBLE;
        end else if (frame_tick) begin
            if (blink_cnt >= CNT_W'(BLINK_HALF - 1)) begin
                blink_cnt <= '0;
                blink_vis <= (blink_vis == BLINK_VISIBLE) ? BLINK_HIDDEN : BLINK_VISIBLE;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

    // Flash state per layer.
    logic [NUM_LAYERS-1:0] flash_phase;

    for (genvar g = 0; g < int'(NUM_LAYERS); g++) begin : g_fx
        layer_fx_ctrl #(
            .FLASH_FRAMES (FLASH_FRAMES)
        ) u_fx (
            .vga_clk      (vga_clk),
            .Reset        (Reset),
            .frame_tick   (frame_tick),
            .flash_trig   (flash_trig[g]),
            .flash_active (flash_active[g]),
            .flash_phase  (flash_phase[g])
        );
    end

    // Stage 1: capture pixel data and fold enables/blink into one on-vector.
    logic [NUM_LAYERS-1:0]       eff_on_c;
    logic [NUM_LAYERS-1:0]       eff_on_q;
    logic [PIX_W-1:0]            bg_q;
    logic [NUM_LAYERS*PIX_W-1:0] layer_q;
    logic                        blank_q;

    assign eff_on_c = pix.layer_on & layer_en
                    & (~blink_en | {NUM_LAYERS{blink_vis == BLINK_VISIBLE}});

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            eff_on_q <= '0;
            bg_q     <= '0;
            layer_q  <= '0;
            blank_q  <= 1'b0;
        end else begin
            eff_on_q <= eff_on_c;
            bg_q     <= pix.bg_rgb;
            layer_q  <= pix.layer_rgb;
            blank_q  <= pix.blank;
        end
    end

    // Stage 2: priority pick, flash override, then blanking.
    prio_t            sel_c;
    logic [PIX_W-1:0] pix_c;

    always_comb begin
        sel_c = prio_select(MAX_LAYERS'(eff_on_q));
        pix_c = bg_q;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (sel_c.valid && (sel_c.idx == IDX_W'(i))) begin
                if (flash_active[i] && flash_phase[i]) begin
                    pix_c = {PIX_W{1'b1}};
                end else begin
                    pix_c = layer_q[i*PIX_W +: PIX_W];
                end
            end
        end
        if (!blank_q) begin
            pix_c = '0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            pix.Red       <= '0;
            pix.Green     <= '0;
            pix.Blue      <= '0;
            pix.blank_out <= 1'b0;
        end else begin
            pix.Red       <= pix_c[3*COLOR_W-1:2*COLOR_W];
            pix.Green     <= pix_c[2*COLOR_W-1:COLOR_W];
            pix.Blue      <= pix_c[COLOR_W-1:0];
            pix.blank_out <= blank_q;
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor (4 layers, 4-bit channels,
// FLASH_FRAMES=3, BLINK_HALF=2). Expected pixels are queued when a vector is
// driven and compared when the DUT produces them two edges later.
module tb_layer_compositor;
    import layer_compositor_pkg::*;

    localparam int unsigned NL = 4;
    localparam int unsigned CW = 4;
    localparam int unsigned FF = 3;
    localparam int unsigned BH = 2;

    localparam logic [11:0] L0  = 12'h5A5;
    localparam logic [11:0] L1  = 12'h111;
    localparam logic [11:0] L2  = 12'h222;
    localparam logic [11:0] L3  = 12'h333;
    localparam logic [11:0] BGA = 12'hABC;
    localparam logic [11:0] BGB = 12'h123;
    localparam logic [11:0] BGC = 12'h0F0;
    localparam logic [11:0] WH  = WHITE;
    localparam logic [11:0] BK  = BLACK;

    typedef struct {
        logic        blank;
        logic [11:0] bg;
        logic [3:0]  on;
        logic [3:0]  en;
        logic [3:0]  bl;
        logic        tick;
        logic [3:0]  trig;
        logic [11:0] exp_rgb;
        logic [3:0]  exp_fa;
    } vec_t;

    typedef struct {
        logic [11:0] rgb;
        logic        blk;
        string       tag;
    } sb_t;

    logic          vga_clk = 1'b0;
    logic          Reset;
    logic          frame_tick;
    logic [NL-1:0] layer_en;
    logic [NL-1:0] blink_en;
    logic [NL-1:0] flash_trig;
    logic [NL-1:0] flash_active;

    int  n_vec = 0;
    int  n_err = 0;
    sb_t sb[$];

    layer_compositor_if #(.NUM_LAYERS(NL), .COLOR_W(CW)) pix ();

    layer_compositor #(
        .NUM_LAYERS   (NL),
        .COLOR_W      (CW),
        .FLASH_FRAMES (FF),
        .BLINK_HALF   (BH)
    ) dut (
        .vga_clk      (vga_clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .layer_en     (layer_en),
        .blink_en     (blink_en),
        .flash_trig   (flash_trig),
        .flash_active (flash_active),
        .pix          (pix)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic vec_t mk(input logic blank, input logic [11:0] bg,
                                input logic [3:0] on, input logic [3:0] en,
                                input logic [3:0] bl, input logic tick,
                                input logic [3:0] trig, input logic [11:0] exp_rgb,
                                input logic [3:0] exp_fa);
        vec_t v;
        v.blank = blank; v.bg = bg; v.on = on; v.en = en; v.bl = bl;
        v.tick = tick; v.trig = trig; v.exp_rgb = exp_rgb; v.exp_fa = exp_fa;
        return v;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Drive one cycle; flash_active is checked right after the edge, the pixel
    // queued by the previous vector is checked now that it has emerged.
    task automatic drive(input vec_t v, input string tag);
        sb_t e;
        pix.blank     = v.blank;
        pix.bg_rgb    = v.bg;
        pix.layer_on  = v.on;
        layer_en      = v.en;
        blink_en      = v.bl;
        frame_tick    = v.tick;
        flash_trig    = v.trig;
        sb.push_back('{rgb: v.exp_rgb, blk: v.blank, tag: tag});
        @(posedge vga_clk);
        #1;
        check({tag, " flash_active"}, 12'(flash_active), 12'(v.exp_fa));
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            check({e.tag, " rgb"}, {pix.Red, pix.Green, pix.Blue}, e.rgb);
            check({e.tag, " blank_out"}, 12'(pix.blank_out), 12'(e.blk));
        end
    endtask

    // One event cycle followed by two quiet cycles with the same expectation.
    task automatic ev(input string tag, input logic tick, input logic [3:0] trig,
                      input logic [3:0] on, input logic [11:0] exp_rgb,
                      input logic [3:0] exp_fa);
        drive(mk(1'b1, BGC, on, 4'hF, 4'h0, tick, trig, exp_rgb, exp_fa), tag);
        repeat (2) drive(mk(1'b1, BGC, on, 4'hF, 4'h0, 1'b0, 4'h0, exp_rgb, exp_fa), {tag, "h"});
    endtask

    task automatic do_reset(input int cycles);
        Reset = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            pix.blank     = 1'($urandom);
            pix.bg_rgb    = 12'($urandom);
            pix.layer_on  = 4'($urandom);
            frame_tick    = 1'($urandom);
            layer_en      = 4'($urandom);
            blink_en      = 4'($urandom);
            flash_trig    = 4'($urandom);
            @(posedge vga_clk);
            #1;
            check("reset rgb", {pix.Red, pix.Green, pix.Blue}, BK);
            check("reset blank_out", 12'(pix.blank_out), 12'h0);
            check("reset flash_active", 12'(flash_active), 12'h0);
        end
        Reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[11];
        logic pre_v;
        logic post_v;

        pix.layer_rgb = {L3, L2, L1, L0};
        do_reset(3);

        // Static compositing: priority, enables, blanking.
        tbl[0]  = mk(1'b1, BGA, 4'b0000, 4'hF,    4'h0,    1'b0, 4'h0, BGA, 4'h0);
        tbl[1]  = mk(1'b1, BGA, 4'b0110, 4'hF,    4'h0,    1'b0, 4'h0, L1,  4'h0);
        tbl[2]  = mk(1'b1, BGA, 4'b0110, 4'b1101, 4'h0,    1'b0, 4'h0, L2,  4'h0);
        tbl[3]  = mk(1'b1, BGA, 4'b1000, 4'hF,    4'h0,    1'b0, 4'h0, L3,  4'h0);
        tbl[4]  = mk(1'b1, BGA, 4'b1111, 4'hF,    4'h0,    1'b0, 4'h0, L0,  4'h0);
        tbl[5]  = mk(1'b0, BGA, 4'b1111, 4'hF,    4'h0,    1'b0, 4'h0, BK,  4'h0);
        tbl[6]  = mk(1'b0, BGA, 4'b0000, 4'hF,    4'h0,    1'b0, 4'h0, BK,  4'h0);
        tbl[7]  = mk(1'b1, BGB, 4'b1001, 4'b1110, 4'h0,    1'b0, 4'h0, L3,  4'h0);
        tbl[8]  = mk(1'b1, BGB, 4'b0000, 4'hF,    4'h0,    1'b0, 4'h0, BGB, 4'h0);
        tbl[9]  = mk(1'b1, BGB, 4'b0110, 4'h0,    4'h0,    1'b0, 4'h0, BGB, 4'h0);
        tbl[10] = mk(1'b1, BGB, 4'b0001, 4'hF,    4'b0001, 1'b0, 4'h0, L0,  4'h0);
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i], $sformatf("tbl%0d", i));
        end

        // Blink: two frames visible, two hidden. The tick cycle itself still
        // sees the phase from before that tick.
        for (int m = 1; m <= 8; m++) begin
            pre_v  = (((m - 1) / 2) % 2) == 0;
            post_v = ((m / 2) % 2) == 0;
            drive(mk(1'b1, BGC, 4'b0001, 4'hF, 4'b0001, 1'b1, 4'h0,
                     pre_v ? L0 : BGC, 4'h0), $sformatf("blink%0d", m));
            repeat (3) drive(mk(1'b1, BGC, 4'b0001, 4'hF, 4'b0001, 1'b0, 4'h0,
                                post_v ? L0 : BGC, 4'h0), $sformatf("blink%0dh", m));
        end

        // Flash on layer 0: counts 3,2,1 -> white, colour, white; then off.
        ev("flash_trig", 1'b0, 4'b0001, 4'b0001, WH, 4'b0001);
        ev("flash_t1",   1'b1, 4'b0000, 4'b0001, L0, 4'b0001);
        ev("flash_t2",   1'b1, 4'b0000, 4'b0001, WH, 4'b0001);
        ev("flash_t3",   1'b1, 4'b0000, 4'b0001, L0, 4'b0000);
        ev("flash_sat",  1'b1, 4'b0000, 4'b0001, L0, 4'b0000);

        // Flash on layer 2 only whitens when layer 2 is the selected one.
        ev("l2_under",   1'b0, 4'b0100, 4'b0101, L0, 4'b0100);
        ev("l2_top",     1'b0, 4'b0000, 4'b0100, WH, 4'b0100);

        // Trigger coincident with frame_tick reloads without decrementing.
        ev("col_trig",   1'b0, 4'b0001, 4'b0001, WH, 4'b0101);
        ev("col_t1",     1'b1, 4'b0000, 4'b0001, L0, 4'b0101);
        ev("col_t2",     1'b1, 4'b0000, 4'b0001, WH, 4'b0101);
        ev("col_both",   1'b1, 4'b0001, 4'b0001, WH, 4'b0001);
        ev("col_t3",     1'b1, 4'b0000, 4'b0001, L0, 4'b0001);
        ev("col_retrig", 1'b0, 4'b0001, 4'b0001, WH, 4'b0001);

        // Mid-frame reset clears an active white flash.
        do_reset(1);
        ev("post_rst",   1'b0, 4'b0000, 4'b0001, L0,  4'b0000);
        ev("post_bg",    1'b0, 4'b0000, 4'b0000, BGC, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
